// File: rtl/trax_move_rx_pkg.sv
// ============================================================================
// Module      : trax_move_rx_pkg
// Description : Shared tile/colour codes, move-word layout and ASCII constants
//               for the Trax move receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package trax_move_rx_pkg;

    localparam logic [1:0] c_TILE_EMPTY  = 2'b00;
    localparam logic [1:0] c_TILE_PLUS   = 2'b01;
    localparam logic [1:0] c_TILE_SLASH  = 2'b10;
    localparam logic [1:0] c_TILE_BSLASH = 2'b11;

    localparam logic c_COLOR_BLACK = 1'b1;
    localparam logic c_COLOR_WHITE = 1'b0;

    localparam int c_ROW_LSB  = 0;
    localparam int c_ROW_W    = 10;
    localparam int c_COL_LSB  = 10;
    localparam int c_COL_W    = 10;
    localparam int c_TILE_LSB = 20;
    localparam int c_TILE_W   = 2;
    localparam int c_MOVE_W   = 22;

    localparam logic [7:0] c_ASCII_LF     = 8'h0A;
    localparam logic [7:0] c_ASCII_CR     = 8'h0D;
    localparam logic [7:0] c_ASCII_AT     = 8'h40;
    localparam logic [7:0] c_ASCII_Z      = 8'h5A;
    localparam logic [7:0] c_ASCII_DASH   = 8'h2D;
    localparam logic [7:0] c_ASCII_B      = 8'h42;
    localparam logic [7:0] c_ASCII_W      = 8'h57;
    localparam logic [7:0] c_ASCII_PLUS   = 8'h2B;
    localparam logic [7:0] c_ASCII_SLASH  = 8'h2F;
    localparam logic [7:0] c_ASCII_BSLASH = 8'h5C;
    localparam logic [7:0] c_ASCII_ZERO   = 8'h30;
    localparam logic [7:0] c_ASCII_NINE   = 8'h39;

    function automatic logic [c_MOVE_W-1:0] pack_move(
        input logic [c_TILE_W-1:0] tile,
        input logic [c_COL_W-1:0]  col,
        input logic [c_ROW_W-1:0]  row
    );
        logic [c_MOVE_W-1:0] mv;
        mv = '0;
        mv[c_TILE_LSB +: c_TILE_W] = tile;
        mv[c_COL_LSB  +: c_COL_W]  = col;
        mv[c_ROW_LSB  +: c_ROW_W]  = row;
        return mv;
    endfunction

endpackage

`default_nettype wire

// File: rtl/trax_uart_rx.sv
// ============================================================================
// Module      : trax_uart_rx
// Description : 8N1 UART receiver with rx synchroniser, half-bit start check
//               and mid-bit sampling; flags good bytes and framing errors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trax_uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err
);

    localparam int c_CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic               r_meta;
    logic               r_sync;
    logic               r_prev;
    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;

    logic w_bit_end;
    logic w_stop_sample;

    assign w_bit_end     = (r_cnt == c_BIT_LAST);
    assign w_stop_sample = (r_state == S_STOP) && w_bit_end;
    // Flags are combinational so the parser acts in the stop-sample cycle.
    assign o_byte_valid  = w_stop_sample &  r_sync;
    assign o_frame_err   = w_stop_sample & ~r_sync;
    assign o_byte        = r_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta  <= 1'b1;
            r_sync  <= 1'b1;
            r_prev  <= 1'b1;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (r_prev && !r_sync) r_state <= S_START;
                end
                S_START: begin
                    if (r_cnt == c_HALF_LAST) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= r_sync ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_shift <= {r_sync, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/trax_move_rx.sv
// ============================================================================
// Module      : trax_move_rx
// Description : Trax receive front end: UART bytes parsed into 22-bit move
//               words {tile,col,row} and game-start colour messages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trax_move_rx #(
    parameter int CLKS_PER_BIT   = 434,
    parameter int MAX_ROW_DIGITS = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [21:0] move_out,
    output logic        end_receive,
    output logic        color,
    output logic        color_valid,
    output logic        parse_err
);

    import trax_move_rx_pkg::*;

    localparam int c_DIG_W = $clog2(MAX_ROW_DIGITS + 1);
    localparam logic [c_DIG_W-1:0] c_DIG_MAX = c_DIG_W'(MAX_ROW_DIGITS);

    localparam logic [2:0] P_IDLE  = 3'd0;
    localparam logic [2:0] P_ROW   = 3'd1;
    localparam logic [2:0] P_EOL   = 3'd2;
    localparam logic [2:0] P_COLOR = 3'd3;
    localparam logic [2:0] P_CEOL  = 3'd4;
    localparam logic [2:0] P_ERR   = 3'd5;

    logic [7:0] w_byte;
    logic       w_byte_valid;
    logic       w_frame_err;

    trax_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk         (clk),
        .rst         (reset),
        .i_rx        (rx),
        .o_byte      (w_byte),
        .o_byte_valid(w_byte_valid),
        .o_frame_err (w_frame_err)
    );

    logic [2:0]          r_state;
    logic [c_COL_W-1:0]  r_col;
    logic [c_ROW_W-1:0]  r_row;
    logic [c_TILE_W-1:0] r_tile;
    logic [c_DIG_W-1:0]  r_digits;
    logic                r_pending;
    logic [c_MOVE_W-1:0] r_move;
    logic                r_end;
    logic                r_color;
    logic                r_color_valid;
    logic                r_parse_err;

    logic                w_is_digit;
    logic                w_is_col;
    logic [c_TILE_W-1:0] w_tile;

    assign w_is_digit = (w_byte >= c_ASCII_ZERO) && (w_byte <= c_ASCII_NINE);
    assign w_is_col   = (w_byte >= c_ASCII_AT)   && (w_byte <= c_ASCII_Z);

    always_comb begin
        w_tile = c_TILE_EMPTY;
        case (w_byte)
            c_ASCII_PLUS:   w_tile = c_TILE_PLUS;
            c_ASCII_SLASH:  w_tile = c_TILE_SLASH;
            c_ASCII_BSLASH: w_tile = c_TILE_BSLASH;
            default:        w_tile = c_TILE_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= P_IDLE;
            r_col         <= '0;
            r_row         <= '0;
            r_tile        <= c_TILE_EMPTY;
            r_digits      <= '0;
            r_pending     <= c_COLOR_WHITE;
            r_move        <= '0;
            r_end         <= 1'b0;
            r_color       <= c_COLOR_WHITE;
            r_color_valid <= 1'b0;
            r_parse_err   <= 1'b0;
        end else begin
            r_end         <= 1'b0;
            r_color_valid <= 1'b0;
            r_parse_err   <= 1'b0;
            if (w_frame_err) begin
                r_state     <= P_ERR;
                r_parse_err <= (r_state != P_ERR);
            end else if (w_byte_valid) begin
                // Every malformed byte lands in ERR; only the entry pulses.
                case (r_state)
                    P_IDLE: begin
                        if (w_is_col) begin
                            r_col    <= c_COL_W'(w_byte - c_ASCII_AT);
                            r_row    <= '0;
                            r_digits <= '0;
                            r_state  <= P_ROW;
                        end else if (w_byte == c_ASCII_DASH) begin
                            r_state <= P_COLOR;
                        end else if (w_byte != c_ASCII_CR && w_byte != c_ASCII_LF) begin
                            r_state     <= P_ERR;
                            r_parse_err <= 1'b1;
                        end
                    end
                    P_ROW: begin
                        if (w_is_digit && r_digits != c_DIG_MAX) begin
                            r_row    <= (r_row << 3) + (r_row << 1) + c_ROW_W'(w_byte[3:0]);
                            r_digits <= r_digits + c_DIG_W'(1);
                        end else if (w_tile != c_TILE_EMPTY && r_digits != '0) begin
                            r_tile  <= w_tile;
                            r_state <= P_EOL;
                        end else begin
                            r_state     <= P_ERR;
                            r_parse_err <= 1'b1;
                        end
                    end
                    P_EOL: begin
                        if (w_byte == c_ASCII_LF) begin
                            r_move  <= pack_move(r_tile, r_col, r_row);
                            r_end   <= 1'b1;
                            r_state <= P_IDLE;
                        end else if (w_byte != c_ASCII_CR) begin
                            r_state     <= P_ERR;
                            r_parse_err <= 1'b1;
                        end
                    end
                    P_COLOR: begin
                        if (w_byte == c_ASCII_B || w_byte == c_ASCII_W) begin
                            r_pending <= (w_byte == c_ASCII_B) ? c_COLOR_BLACK : c_COLOR_WHITE;
                            r_state   <= P_CEOL;
                        end else begin
                            r_state     <= P_ERR;
                            r_parse_err <= 1'b1;
                        end
                    end
                    P_CEOL: begin
                        if (w_byte == c_ASCII_LF) begin
                            r_color       <= r_pending;
                            r_color_valid <= 1'b1;
                            r_state       <= P_IDLE;
                        end else if (w_byte != c_ASCII_CR) begin
                            r_state     <= P_ERR;
                            r_parse_err <= 1'b1;
                        end
                    end
                    default: begin
                        if (w_byte == c_ASCII_LF) r_state <= P_IDLE;
                    end
                endcase
            end
        end
    end

    assign move_out    = r_move;
    assign end_receive = r_end;
    assign color       = r_color;
    assign color_valid = r_color_valid;
    assign parse_err   = r_parse_err;

endmodule

`default_nettype wire

// File: tb/tb_trax_move_rx.sv
// ============================================================================
// Module      : tb_trax_move_rx
// Description : Self-checking bench for trax_move_rx: line-level reference
//               model plus per-cycle output comparison.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trax_move_rx;

    localparam int BIT   = 8;
    localparam int MAXD  = 3;

    logic        clk;
    logic        reset;
    logic        rx;
    logic [21:0] move_out;
    logic        end_receive;
    logic        color;
    logic        color_valid;
    logic        parse_err;

    trax_move_rx #(
        .CLKS_PER_BIT  (BIT),
        .MAX_ROW_DIGITS(MAXD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .move_out   (move_out),
        .end_receive(end_receive),
        .color      (color),
        .color_valid(color_valid),
        .parse_err  (parse_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: committed outputs plus what the line in flight should do.
    logic [21:0] m_move       = '0;
    logic        m_color      = 1'b0;
    logic [21:0] m_next_move  = '0;
    logic        m_next_color = 1'b0;
    logic        m_exp_commit = 1'b0;
    logic        m_exp_color  = 1'b0;
    logic        m_exp_err    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-line interpretation of the Trax notation; kind 0=none 1=move 2=colour 3=error.
    function automatic void model_line(input string s, output int kind,
                                       output logic [21:0] mv, output logic c);
        int b, e, nd, row, col;
        logic [1:0] tile;
        kind = 0; mv = '0; c = 1'b0; row = 0; tile = 2'b00;
        b = 0;
        while (b < s.len() && (s[b] == 8'h0A || s[b] == 8'h0D)) b++;
        if (b >= s.len()) return;
        e = s.len() - 2;
        while (e > b && s[e] == 8'h0D) e--;
        if (s[b] == 8'h2D) begin
            kind = ((e == b + 1) && (s[e] == 8'h42 || s[e] == 8'h57)) ? 2 : 3;
            c = (s[e] == 8'h42);
            return;
        end
        if (s[b] < 8'h40 || s[b] > 8'h5A) begin kind = 3; return; end
        col = int'(s[b]) - 64;
        nd = e - b - 1;
        if (nd < 1 || nd > MAXD) begin kind = 3; return; end
        for (int i = b + 1; i < e; i++) begin
            if (s[i] < 8'h30 || s[i] > 8'h39) begin kind = 3; return; end
            row = row * 10 + (int'(s[i]) - 48);
        end
        case (s[e])
            8'h2B:   tile = 2'b01;
            8'h2F:   tile = 2'b10;
            8'h5C:   tile = 2'b11;
            default: begin kind = 3; return; end
        endcase
        kind = 1;
        mv = {tile, col[9:0], row[9:0]};
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0; wait_cycles(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i]; wait_cycles(BIT);
        end
        rx = stop; wait_cycles(BIT);
        if (!stop) begin
            rx = 1'b1; wait_cycles(BIT);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic expect_done(input string tag);
        wait_cycles(2);
        check({tag, "_end_seen"},   {31'd0, m_exp_commit}, 32'd0);
        check({tag, "_color_seen"}, {31'd0, m_exp_color},  32'd0);
        check({tag, "_err_seen"},   {31'd0, m_exp_err},    32'd0);
    endtask

    task automatic send_line(input string tag, input string s);
        int kind;
        logic [21:0] mv;
        logic c;
        model_line(s, kind, mv, c);
        m_next_move  = mv;
        m_next_color = c;
        m_exp_commit = (kind == 1);
        m_exp_color  = (kind == 2);
        m_exp_err    = (kind == 3);
        send_str(s);
        expect_done(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_move"},   {10'd0, move_out},    32'd0);
        check({tag, "_end"},    {31'd0, end_receive}, 32'd0);
        check({tag, "_color"},  {31'd0, color},       32'd0);
        check({tag, "_cvalid"}, {31'd0, color_valid}, 32'd0);
        check({tag, "_perr"},   {31'd0, parse_err},   32'd0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("pulse_exclusive", {31'd0, end_receive & color_valid}, 32'd0);
            if (end_receive) begin
                check("end_expected", {31'd0, m_exp_commit}, 32'd1);
                check("move_commit", {10'd0, move_out}, {10'd0, m_next_move});
                m_move = m_next_move;
                m_exp_commit = 1'b0;
            end else begin
                check("move_hold", {10'd0, move_out}, {10'd0, m_move});
            end
            if (color_valid) begin
                check("color_expected", {31'd0, m_exp_color}, 32'd1);
                check("color_commit", {31'd0, color}, {31'd0, m_next_color});
                m_color = m_next_color;
                m_exp_color = 1'b0;
            end else begin
                check("color_hold", {31'd0, color}, {31'd0, m_color});
            end
            if (parse_err) begin
                check("err_expected", {31'd0, m_exp_err}, 32'd1);
                m_exp_err = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rx = 1'b1;
        reset = 1'b1;
        wait_cycles(4);
        check_all_zero("reset");
        reset = 1'b0;
        wait_cycles(3);

        send_line("t1", "A3+\n");
        check("t1_literal", {10'd0, move_out}, 32'h100403);

        send_line("t2", "@0/\r\n");
        check("t2_literal", {10'd0, move_out}, 32'h200000);

        send_line("t3b", "-B\n");
        check("t3b_literal", {31'd0, color}, 32'd1);
        send_line("t3w", "-W\r\n");
        check("t3w_literal", {31'd0, color}, 32'd0);
        check("t3_move_kept", {10'd0, move_out}, 32'h200000);

        send_line("t4err", "B1234+\n");
        check("t4_move_kept", {10'd0, move_out}, 32'h200000);
        send_line("t4", "C12\\\n");
        check("t4_literal", {10'd0, move_out}, 32'h300C0C);

        // Framing error on 'A', remainder of that line must be swallowed.
        m_exp_commit = 1'b0;
        m_exp_color  = 1'b0;
        m_exp_err    = 1'b1;
        send_byte(8'h41, 1'b0);
        send_str("1+\n");
        expect_done("t5err");
        check("t5_move_kept", {10'd0, move_out}, 32'h300C0C);
        send_line("t5", "A1+\n");
        check("t5_literal", {10'd0, move_out}, 32'h100401);

        // Short low glitch on an idle line must not produce a byte.
        rx = 1'b0; wait_cycles(2);
        rx = 1'b1; wait_cycles(3 * BIT);
        send_line("glitch", "Z999\\\n");
        check("max_row_literal", {10'd0, move_out}, 32'h306BE7);
        send_line("nodigit", "E+\n");
        send_line("badcol", "a1+\n");
        send_line("b2b", "E7+\n");
        check("b2b_literal", {10'd0, move_out}, 32'h101407);

        send_str("T1");
        reset = 1'b1;
        wait_cycles(3);
        check_all_zero("t6_reset");
        m_move = '0;
        m_color = 1'b0;
        m_exp_commit = 1'b0;
        m_exp_color = 1'b0;
        m_exp_err = 1'b0;
        reset = 1'b0;
        wait_cycles(2);
        send_line("t6", "D5/\n");
        check("t6_literal", {10'd0, move_out}, 32'h201005);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
